// File: rtl/riscv_types_pkg.sv
// RV32A atomic operation encodings shared by the load/store path.
package riscv_types;

  // AMO funct5 field; only these values are executed, anything else is a failing no-op.
  typedef enum logic [4:0] {
    AmoAdd  = 5'b00000,
    AmoSwap = 5'b00001,
    AmoLr   = 5'b00010,
    AmoSc   = 5'b00011,
    AmoXor  = 5'b00100,
    AmoOr   = 5'b01000,
    AmoAnd  = 5'b01100,
    AmoMin  = 5'b10000,
    AmoMax  = 5'b10100,
    AmoMinu = 5'b11000,
    AmoMaxu = 5'b11100
  } amo_t;

  // True for the read-modify-write flavours (everything except LR, SC and unknown codes).
  function automatic logic amo_is_rmw(logic [4:0] fn5);
    logic rmw;
    rmw = 1'b0;
    case (amo_t'(fn5))
      AmoAdd, AmoSwap, AmoXor, AmoOr, AmoAnd,
      AmoMin, AmoMax, AmoMinu, AmoMaxu: rmw = 1'b1;
      default:                          rmw = 1'b0;
    endcase
    return rmw;
  endfunction

endpackage

// File: rtl/amo_rmw_alu.sv
// Combinational modify step of an AMO: new = f(old memory value, rs2).
module amo_rmw_alu
  import riscv_types::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] a_i,      // old memory value
  input  logic [WIDTH-1:0] b_i,      // rs2
  output logic [WIDTH-1:0] result_o
);

  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(a_i) < $signed(b_i);
  assign lt_u = a_i < b_i;

  // Select the modify function; equal operands fall through to b, which equals a.
  always_comb begin
    result_o = b_i;
    case (amo_t'(op_i))
      AmoAdd:  result_o = a_i + b_i;
      AmoSwap: result_o = b_i;
      AmoXor:  result_o = a_i ^ b_i;
      AmoOr:   result_o = a_i | b_i;
      AmoAnd:  result_o = a_i & b_i;
      AmoMin:  result_o = lt_s ? a_i : b_i;
      AmoMax:  result_o = lt_s ? b_i : a_i;
      AmoMinu: result_o = lt_u ? a_i : b_i;
      AmoMaxu: result_o = lt_u ? b_i : a_i;
      default: result_o = b_i;
    endcase
  end

endmodule

// File: rtl/amo_rmw_unit.sv
// Sequential RV32A engine: one AMO/LR/SC at a time, with a per-port LR/SC reservation.
module amo_rmw_unit
  import riscv_types::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned GRANULE_BITS = 2,
  localparam int unsigned PortW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PortW-1:0]  req_port,
  input  logic [4:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_data,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_data_valid,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PortW-1:0]  rsp_port,
  output logic [WIDTH-1:0]  rsp_data,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr
);

  localparam int unsigned TagW = ADDR_W - GRANULE_BITS;

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrReq, StRsp} state_e;

  state_e            state_q, state_d;
  logic [4:0]        op_q, op_d;
  logic [PortW-1:0]  port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [NUM_PORTS-1:0] res_valid_q, res_valid_d;
  logic [TagW-1:0]   res_tag_q [NUM_PORTS];
  logic [TagW-1:0]   res_tag_d [NUM_PORTS];

  logic [TagW-1:0]   req_tag;
  logic [TagW-1:0]   addr_tag;
  logic [TagW-1:0]   snoop_tag;
  logic              req_match;
  logic [WIDTH-1:0]  alu_result;

  assign req_tag   = req_addr[ADDR_W-1:GRANULE_BITS];
  assign addr_tag  = addr_q[ADDR_W-1:GRANULE_BITS];
  assign snoop_tag = snoop_addr[ADDR_W-1:GRANULE_BITS];
  assign req_match = res_valid_q[req_port] && (res_tag_q[req_port] == req_tag);

  amo_rmw_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op_i     (op_q),
    .a_i      (mem_rd_data),
    .b_i      (data_q),
    .result_o (alu_result)
  );

  // Sequencing, operand capture and reservation bookkeeping.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    port_d      = port_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_data_d   = wr_data_q;
    rsp_data_d  = rsp_data_q;
    res_valid_d = res_valid_q;
    res_tag_d   = res_tag_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d   = req_op;
          port_d = req_port;
          addr_d = req_addr;
          data_d = req_data;
          if (req_op == AmoLr) begin
            state_d = StRdReq;
          end else if (req_op == AmoSc) begin
            // SC always consumes its own reservation, pass or fail.
            res_valid_d[req_port] = 1'b0;
            if (req_match) begin
              wr_data_d  = req_data;
              rsp_data_d = '0;
              state_d    = StWrReq;
            end else begin
              rsp_data_d = WIDTH'(1);
              state_d    = StRsp;
            end
          end else if (amo_is_rmw(req_op)) begin
            state_d = StRdReq;
          end else begin
            rsp_data_d = '0;
            state_d    = StRsp;
          end
        end
      end
      StRdReq: begin
        if (mem_rd_ready) state_d = StRdWait;
      end
      StRdWait: begin
        if (mem_rd_data_valid) begin
          rsp_data_d = mem_rd_data;
          if (op_q == AmoLr) begin
            res_valid_d[port_q] = 1'b1;
            res_tag_d[port_q]   = addr_tag;
            state_d             = StRsp;
          end else begin
            wr_data_d = alu_result;
            state_d   = StWrReq;
          end
        end
      end
      StWrReq: begin
        if (mem_wr_ready) begin
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (res_tag_d[i] == addr_tag) res_valid_d[i] = 1'b0;
          end
          state_d = StRsp;
        end
      end
      StRsp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Snoop is applied last so it beats an LR setting the same granule this cycle.
    if (snoop_valid) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (res_tag_d[i] == snoop_tag) res_valid_d[i] = 1'b0;
      end
    end
  end

  // State and captured-operand registers; reset clears all payload and reservations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      port_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_data_q   <= '0;
      rsp_data_q  <= '0;
      res_valid_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) res_tag_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      port_q      <= port_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_data_q   <= wr_data_d;
      rsp_data_q  <= rsp_data_d;
      res_valid_q <= res_valid_d;
      res_tag_q   <= res_tag_d;
    end
  end

  // Handshake outputs are pure state decodes; payloads come straight from registers.
  assign req_ready    = (state_q == StIdle);
  assign mem_rd_valid = (state_q == StRdReq);
  assign mem_wr_valid = (state_q == StWrReq);
  assign rsp_valid    = (state_q == StRsp);
  assign mem_rd_addr  = addr_q;
  assign mem_wr_addr  = addr_q;
  assign mem_wr_data  = wr_data_q;
  assign rsp_port     = port_q;
  assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_amo_rmw_unit.sv
// Self-checking bench for amo_rmw_unit: directed cases plus random traffic against a model.
module tb_amo_rmw_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [0:0]  req_port;
  logic [4:0]  req_op;
  logic [31:0] req_addr, req_data;
  logic        mem_rd_valid, mem_rd_ready;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_data_valid;
  logic [31:0] mem_rd_data;
  logic        mem_wr_valid, mem_wr_ready;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic        rsp_valid, rsp_ready;
  logic [0:0]  rsp_port;
  logic [31:0] rsp_data;
  logic        snoop_valid;
  logic [31:0] snoop_addr;

  amo_rmw_unit #(
    .WIDTH        (32),
    .ADDR_W       (32),
    .NUM_PORTS    (2),
    .GRANULE_BITS (2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_port          (req_port),
    .req_op            (req_op),
    .req_addr          (req_addr),
    .req_data          (req_data),
    .mem_rd_valid      (mem_rd_valid),
    .mem_rd_ready      (mem_rd_ready),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_data_valid (mem_rd_data_valid),
    .mem_rd_data       (mem_rd_data),
    .mem_wr_valid      (mem_wr_valid),
    .mem_wr_ready      (mem_wr_ready),
    .mem_wr_addr       (mem_wr_addr),
    .mem_wr_data       (mem_wr_data),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_port          (rsp_port),
    .rsp_data          (rsp_data),
    .snoop_valid       (snoop_valid),
    .snoop_addr        (snoop_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Bench memory and reference reservation state.
  logic [31:0] mem [logic [31:0]];
  bit          res_v [2];
  logic [31:0] res_a [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit same_granule(input logic [31:0] a, input logic [31:0] b);
    return (a / 4) == (b / 4);
  endfunction

  function automatic bit is_amo(input logic [4:0] op);
    return op inside {5'd0, 5'd1, 5'd4, 5'd8, 5'd12, 5'd16, 5'd20, 5'd24, 5'd28};
  endfunction

  function automatic logic [31:0] amo_ref(input logic [4:0] op, input logic [31:0] m,
                                          input logic [31:0] r);
    int sm;
    int sr;
    sm = m;
    sr = r;
    case (op)
      5'd0:    return m + r;
      5'd1:    return r;
      5'd4:    return m ^ r;
      5'd8:    return m | r;
      5'd12:   return m & r;
      5'd16:   return (sm < sr) ? m : r;
      5'd20:   return (sm > sr) ? m : r;
      5'd24:   return (m < r) ? m : r;
      5'd28:   return (m > r) ? m : r;
      default: return r;
    endcase
  endfunction

  function automatic void clear_matching(input logic [31:0] a);
    for (int i = 0; i < 2; i++) if (same_granule(res_a[i], a)) res_v[i] = 1'b0;
  endfunction

  task automatic snoop_pulse(input logic [31:0] a);
    @(negedge clk);
    snoop_valid = 1'b1;
    snoop_addr  = a;
    clear_matching(a);
    @(negedge clk);
    snoop_valid = 1'b0;
  endtask

  // One transaction: predict, drive the request, act as memory and consumer, then compare.
  task automatic run_txn(input int p, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] d, input int rd_st, input int wr_st,
                         input int rsp_st, input bit lr_snoop, input logic [31:0] lr_snoop_a,
                         output logic [31:0] got_rsp, output logic [31:0] got_wd);
    logic [31:0] old, e_rsp, e_wd, got_wa, got_port;
    logic [31:0] hold_ra, hold_wa, hold_wd, hold_rsp, rd_a;
    int e_rd, e_wr, e_lat, n_rd, n_wr, acc_cyc, rsp_cyc, rs, ws, ss;
    bit accepted, done, rd_pend, rd_next, rd_seen, wr_seen, rsp_seen, no_stall;
    string t;

    old = mem_rd(a);
    e_rd = 0; e_wr = 0; e_wd = 32'h0; e_rsp = 32'h0; e_lat = 1;
    if (op == 5'd2) begin
      e_rd = 1; e_rsp = old; e_lat = 3;
      res_v[p] = 1'b1; res_a[p] = a;
      if (lr_snoop) clear_matching(lr_snoop_a);
    end else if (op == 5'd3) begin
      if (res_v[p] && same_granule(res_a[p], a)) begin
        e_wr = 1; e_wd = d; e_rsp = 0; e_lat = 2;
        res_v[p] = 1'b0;
        clear_matching(a);
      end else begin
        e_rsp = 1; e_lat = 1;
        res_v[p] = 1'b0;
      end
    end else if (is_amo(op)) begin
      e_rd = 1; e_wr = 1; e_wd = amo_ref(op, old, d); e_rsp = old; e_lat = 4;
      clear_matching(a);
    end

    got_rsp = 32'hDEAD_BEEF; got_wd = 32'hDEAD_BEEF; got_wa = 32'hDEAD_BEEF;
    got_port = 32'hDEAD_BEEF;
    rs = rd_st; ws = wr_st; ss = rsp_st;
    no_stall = (rd_st == 0) && (wr_st == 0) && (rsp_st == 0);
    accepted = 0; done = 0; rd_pend = 0; rd_seen = 0; wr_seen = 0; rsp_seen = 0;
    n_rd = 0; n_wr = 0; acc_cyc = -1; rsp_cyc = -1; rd_a = 0;
    hold_ra = 0; hold_wa = 0; hold_wd = 0; hold_rsp = 0;

    @(negedge clk);
    req_valid = 1'b1; req_port = p[0]; req_op = op; req_addr = a; req_data = d;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (accepted) req_valid = 1'b0;
      mem_rd_data_valid = rd_pend;
      mem_rd_data       = rd_pend ? mem_rd(rd_a) : $urandom;
      snoop_valid       = rd_pend && lr_snoop;
      snoop_addr        = lr_snoop_a;
      rd_next = 1'b0;
      mem_rd_ready = 1'b0; mem_wr_ready = 1'b0; rsp_ready = 1'b0;
      if (!accepted && req_valid && req_ready) begin
        accepted = 1; acc_cyc = cyc;
      end
      if (mem_rd_valid) begin
        if (!rd_seen) begin
          rd_seen = 1; hold_ra = mem_rd_addr;
        end else check_eq("rd_addr_hold", mem_rd_addr, hold_ra);
        if (rs > 0) rs--;
        else begin
          mem_rd_ready = 1'b1; n_rd++; rd_next = 1'b1; rd_a = mem_rd_addr;
        end
      end
      if (mem_wr_valid) begin
        if (!wr_seen) begin
          wr_seen = 1; hold_wa = mem_wr_addr; hold_wd = mem_wr_data;
        end else begin
          check_eq("wr_addr_hold", mem_wr_addr, hold_wa);
          check_eq("wr_data_hold", mem_wr_data, hold_wd);
        end
        if (ws > 0) ws--;
        else begin
          mem_wr_ready = 1'b1; n_wr++;
          got_wa = mem_wr_addr; got_wd = mem_wr_data;
          mem[mem_wr_addr] = mem_wr_data;
        end
      end
      if (rsp_valid) begin
        if (!rsp_seen) begin
          rsp_seen = 1; rsp_cyc = cyc; hold_rsp = rsp_data;
        end else check_eq("rsp_data_hold", rsp_data, hold_rsp);
        if (ss > 0) ss--;
        else begin
          rsp_ready = 1'b1; got_rsp = rsp_data; got_port = 32'(rsp_port); done = 1;
        end
      end
      @(posedge clk);
      rd_pend = rd_next;
      @(negedge clk);
    end
    req_valid = 1'b0; mem_rd_ready = 1'b0; mem_wr_ready = 1'b0; rsp_ready = 1'b0;
    mem_rd_data_valid = 1'b0; snoop_valid = 1'b0;

    t = $sformatf("op%0d@%h", op, a);
    check_eq({"rsp_seen ", t}, 32'(done), 32'd1);
    check_eq({"rsp_data ", t}, got_rsp, e_rsp);
    check_eq({"rsp_port ", t}, got_port, 32'(p));
    check_eq({"reads ", t}, 32'(n_rd), 32'(e_rd));
    check_eq({"writes ", t}, 32'(n_wr), 32'(e_wr));
    if (e_wr != 0) begin
      check_eq({"wr_addr ", t}, got_wa, a);
      check_eq({"wr_data ", t}, got_wd, e_wd);
    end
    if (no_stall) check_eq({"latency ", t}, 32'(rsp_cyc - acc_cyc), 32'(e_lat));
  endtask

  logic [31:0] r, w;
  logic [4:0]  amos [9];
  logic [4:0]  unk [5];
  int          rp, sel, s0, s1, s2;
  logic [4:0]  rop;
  logic [31:0] ra, rd, sa;
  bit          rsn;

  initial begin
    amos = '{5'd0, 5'd1, 5'd4, 5'd8, 5'd12, 5'd16, 5'd20, 5'd24, 5'd28};
    unk  = '{5'd5, 5'd6, 5'd7, 5'd9, 5'd31};
    res_v = '{0, 0};
    res_a = '{32'h0, 32'h0};
    rst_n = 1'b0;
    req_valid = 0; req_port = 0; req_op = 0; req_addr = 0; req_data = 0;
    mem_rd_ready = 0; mem_rd_data_valid = 0; mem_rd_data = 0; mem_wr_ready = 0;
    rsp_ready = 0; snoop_valid = 0; snoop_addr = 0;

    // Reset state.
    #12;
    check_eq("rst_rd_valid", 32'(mem_rd_valid), 32'd0);
    check_eq("rst_wr_valid", 32'(mem_wr_valid), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);

    // ALU corner cases.
    mem[32'h40] = 32'h7FFF_FFFF;
    run_txn(0, 5'd0, 32'h40, 32'h1, 0, 0, 0, 0, 0, r, w);
    check_eq("amoadd_wr", w, 32'h8000_0000);
    check_eq("amoadd_rsp", r, 32'h7FFF_FFFF);
    mem[32'h44] = 32'hFFFF_FFFE;
    run_txn(1, 5'd16, 32'h44, 32'h1, 0, 0, 0, 0, 0, r, w);
    check_eq("amomin_wr", w, 32'hFFFF_FFFE);
    mem[32'h48] = 32'hFFFF_FFFE;
    run_txn(0, 5'd24, 32'h48, 32'h1, 0, 0, 0, 0, 0, r, w);
    check_eq("amominu_wr", w, 32'h1);
    mem[32'h4C] = 32'h5;
    run_txn(0, 5'd20, 32'h4C, 32'h5, 0, 0, 0, 0, 0, r, w);
    check_eq("amomax_eq_wr", w, 32'h5);

    // Reservation granularity.
    run_txn(0, 5'd2, 32'h100, 0, 0, 0, 0, 0, 0, r, w);
    run_txn(0, 5'd3, 32'h104, 32'h77, 0, 0, 0, 0, 0, r, w);
    check_eq("sc_other_granule", r, 32'd1);
    run_txn(0, 5'd3, 32'h100, 32'h77, 0, 0, 0, 0, 0, r, w);
    check_eq("sc_no_res", r, 32'd1);

    // Invalidation by a remote AMO, by a snoop, and the clean success case.
    run_txn(0, 5'd2, 32'h200, 0, 0, 0, 0, 0, 0, r, w);
    run_txn(1, 5'd1, 32'h203, 32'hABCD, 0, 0, 0, 0, 0, r, w);
    run_txn(0, 5'd3, 32'h200, 32'h1234, 0, 0, 0, 0, 0, r, w);
    check_eq("sc_after_amo", r, 32'd1);
    run_txn(0, 5'd2, 32'h200, 0, 0, 0, 0, 0, 0, r, w);
    snoop_pulse(32'h200);
    run_txn(0, 5'd3, 32'h200, 32'h1234, 0, 0, 0, 0, 0, r, w);
    check_eq("sc_after_snoop", r, 32'd1);
    run_txn(0, 5'd2, 32'h200, 0, 0, 0, 0, 0, 0, r, w);
    run_txn(0, 5'd3, 32'h200, 32'h1234, 0, 0, 0, 0, 0, r, w);
    check_eq("sc_success_rsp", r, 32'd0);
    check_eq("sc_success_wr", w, 32'h1234);

    // Snoop coinciding with the LR reservation set: same granule wins, other granule does not.
    run_txn(1, 5'd2, 32'h300, 0, 0, 0, 0, 1, 32'h301, r, w);
    run_txn(1, 5'd3, 32'h300, 32'h55, 0, 0, 0, 0, 0, r, w);
    check_eq("sc_lr_snoop_same", r, 32'd1);
    run_txn(1, 5'd2, 32'h300, 0, 0, 0, 0, 1, 32'h310, r, w);
    run_txn(1, 5'd3, 32'h300, 32'h55, 0, 0, 0, 0, 0, r, w);
    check_eq("sc_lr_snoop_other", r, 32'd0);

    // Unknown funct5 and back-pressure on every handshake.
    run_txn(0, 5'd5, 32'h400, 32'h9, 0, 0, 0, 0, 0, r, w);
    run_txn(1, 5'd4, 32'h500, 32'hF0F0_F0F0, 3, 2, 2, 0, 0, r, w);

    // Random traffic over a few granules so reservations hit and miss.
    for (int k = 0; k < 80; k++) begin
      rp  = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      if (sel < 3) rop = 5'd2;
      else if (sel < 6) rop = 5'd3;
      else if (sel == 6) rop = unk[$urandom_range(0, 4)];
      else rop = amos[$urandom_range(0, 8)];
      ra  = 32'h100 + 32'($urandom_range(0, 11));
      rd  = $urandom;
      s0  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      s1  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      s2  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      rsn = (rop == 5'd2) && ($urandom_range(0, 3) == 0);
      sa  = 32'h100 + 32'($urandom_range(0, 11));
      if ($urandom_range(0, 5) == 0) snoop_pulse(32'h100 + 32'($urandom_range(0, 11)));
      run_txn(rp, rop, ra, rd, s0, s1, s2, rsn, sa, r, w);
    end

    // Asynchronous reset in the middle of an AMO's read.
    run_txn(0, 5'd2, 32'h600, 0, 0, 0, 0, 0, 0, r, w);
    @(negedge clk);
    req_valid = 1'b1; req_port = 0; req_op = 5'd0; req_addr = 32'h700; req_data = 32'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    mem_rd_ready = 1'b1;
    check_eq("rstmid_rd_valid_pre", 32'(mem_rd_valid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    mem_rd_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstmid_rd_valid", 32'(mem_rd_valid), 32'd0);
    check_eq("rstmid_wr_valid", 32'(mem_wr_valid), 32'd0);
    check_eq("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rstmid_rsp_data", rsp_data, 32'd0);
    check_eq("rstmid_rd_addr", mem_rd_addr, 32'd0);
    check_eq("rstmid_wr_addr", mem_wr_addr, 32'd0);
    check_eq("rstmid_wr_data", mem_wr_data, 32'd0);
    res_v = '{0, 0};
    @(negedge clk);
    rst_n = 1'b1;
    mem_rd_data_valid = 1'b1;
    mem_rd_data = 32'hBAD0_BAD0;
    @(posedge clk);
    @(negedge clk);
    mem_rd_data_valid = 1'b0;
    check_eq("late_rdata_ready", 32'(req_ready), 32'd1);
    check_eq("late_rdata_wr", 32'(mem_wr_valid), 32'd0);
    check_eq("late_rdata_rsp", 32'(rsp_valid), 32'd0);
    check_eq("late_rdata_rd", 32'(mem_rd_valid), 32'd0);
    mem[32'h700] = 32'd10;
    run_txn(0, 5'd0, 32'h700, 32'd3, 0, 0, 0, 0, 0, r, w);
    check_eq("post_rst_amo_wr", w, 32'd13);
    run_txn(0, 5'd3, 32'h600, 32'h66, 0, 0, 0, 0, 0, r, w);
    check_eq("post_rst_sc", r, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
